// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// digits_for() gives the BCD digits needed to hold any WIDTH-bit unsigned value.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // ceil(width * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
  function automatic int digits_for(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one bit per cycle, valid/ready on both
// sides, with a no-bubble reload when a result retires and a new word arrives.
module bin2bcd_seq_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    bin_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [WIDTH-1:0]         bin_sr;
  logic [BCD_W-1:0]         bcd_r;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+WIDTH-1:0]   cat_sh;
  logic                     ovf_r;
  logic                     load;
  logic                     shift_en;
  logic                     last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (bcd_r[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // Adjust first, then shift the combined {bcd, bin} register left by one.
  assign cat_sh     = {bcd_adj, bin_sr} << 1;
  assign last_shift = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_shift) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result and iteration count: reset so bcd_out is never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      bcd_r <= '0;
      ovf_r <= 1'b0;
    end else if (load) begin
      cnt   <= CNT_W'(WIDTH);
      bcd_r <= '0;
      ovf_r <= 1'b0;
    end else if (shift_en) begin
      cnt   <= cnt - CNT_W'(1);
      bcd_r <= cat_sh[BCD_W+WIDTH-1:WIDTH];
      ovf_r <= ovf_r | bcd_adj[BCD_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (load)          bin_sr <= bin_in;
    else if (shift_en) bin_sr <= cat_sh[WIDTH-1:0];
  end

  assign bcd_out  = bcd_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Scoreboard bench for bin2bcd_seq_ctrl: main 8-bit/3-digit instance plus
// 8-bit/2-digit and 16-bit/5-digit instances for truncation and width cases.
module tb_bin2bcd_seq_ctrl;

  localparam int P = 10;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, overflow;
  logic [7:0]  bin_in;
  logic [11:0] bcd_out;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_overflow;
  logic [7:0]  a_bin;
  logic [7:0]  a_bcd;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_overflow;
  logic [15:0] b_bin;
  logic [19:0] b_bcd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  time  pops[$];
  time  t_acc;

  bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .overflow(overflow)
  );

  bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .bin_in(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd_out(a_bcd), .overflow(a_overflow)
  );

  bin2bcd_seq_ctrl #(.WIDTH(16), .DIGITS(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .bin_in(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd_out(b_bcd), .overflow(b_overflow)
  );

  initial clk = 1'b0;
  always #(P/2) clk = ~clk;

  initial begin
    #(200000);
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bcd_model(input int unsigned v, input int digits);
    logic [63:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic ovf_model(input int unsigned v, input int digits);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return (longint'(v) >= lim);
  endfunction

  // Monitor: each negedge with out_valid & out_ready precedes exactly one handshake edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_out", 64'(bcd_out), 64'hDEAD);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("bcd_out", 64'(bcd_out), 64'(e.bcd));
        check("overflow", 64'(overflow), 64'(e.ovf));
      end
      pops.push_back($time);
    end
  end

  // Called just after a posedge; returns just after the acceptance edge.
  task automatic send(input int unsigned v);
    int n;
    exp_t e;
    logic [63:0] m;
    bin_in   = 8'(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n < 200), 64'd1);
    m     = bcd_model(v, 3);
    e.bcd = m[11:0];
    e.ovf = ovf_model(v, 3);
    sbq.push_back(e);
    t_acc = $time;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin_in   = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned vals2[3];
    int unsigned avals[3];
    int unsigned bvals[3];
    time t7_pop, t200_acc;
    int  np, n, seen;
    logic [63:0] m;

    vals2 = '{0, 99, 100};
    avals = '{255, 99, 100};
    bvals = '{65535, 10000, 9999};

    rst = 1'b1;
    in_valid = 1'b0; bin_in = '0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_bin = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_bin = '0; b_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bcd_out", 64'(bcd_out), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Full-scale value and acceptance-to-result latency
    send(255);
    wait_drain();
    check("latency_255", 64'(pops[$] - t_acc), 64'(9 * P));

    foreach (vals2[i]) send(vals2[i]);
    wait_drain();

    // Back-to-back: second word accepted on the edge the first retires
    send(7);
    send(200);
    t200_acc = t_acc;
    wait_drain();
    t7_pop = pops[pops.size()-2];
    check("b2b_same_edge", 64'(t200_acc), 64'(t7_pop));
    check("b2b_spacing", 64'(pops[$] - t7_pop), 64'(9 * P));

    // Backpressure: result held, in_ready low, then a single handshake
    out_ready = 1'b0;
    send(123);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_bcd_out", 64'(bcd_out), 64'h123);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    np = pops.size();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_one_handshake", 64'(pops.size() - np), 64'd1);
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) send($urandom_range(0, 255));
    wait_drain();

    // Reset in the middle of a conversion
    send(77);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_bcd_out", 64'(bcd_out), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_result", 64'(seen), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(42);
    wait_drain();

    // Truncated output: two digits
    foreach (avals[i]) begin
      a_bin = 8'(avals[i]);
      a_in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!a_out_valid && n < 50) begin @(negedge clk); n++; end
      m = bcd_model(avals[i], 2);
      check("d2_bcd", 64'(a_bcd), m);
      check("d2_overflow", 64'(a_overflow), 64'(ovf_model(avals[i], 2)));
      @(posedge clk);
      #1;
    end

    // Wide input: sixteen bits into five digits
    foreach (bvals[i]) begin
      b_bin = 16'(bvals[i]);
      b_in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!b_out_valid && n < 50) begin @(negedge clk); n++; end
      m = bcd_model(bvals[i], 5);
      check("w16_bcd", 64'(b_bcd), m);
      check("w16_overflow", 64'(b_overflow), 64'(ovf_model(bvals[i], 5)));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
